// File: rtl/store_narrow_rmw.sv
// Sub-word store narrowing onto a word-only sync DM: word stores write at T+1, byte/half RMW writes at T+3,
// illegal requests pulse misalign at T+1; req_ready only in IDLE, so requests outside IDLE are simply not taken.
module store_narrow_rmw #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [1:0]        req_size,
   output logic              done,
   output logic              misalign,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [31:0]       mem_rdata,
   output logic              mem_wr_en,
   output logic [31:0]       mem_wdata
);

   typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        lane_q;
   logic [31:0]       data_q;
   logic [1:0]        size_q;
   logic [31:0]       wbuf;
   logic              illegal;
   logic [31:0]       merged;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

   always_comb begin
      illegal = (req_size == SZ_ILL)
             || (req_size == SZ_HALF && req_addr[0])
             || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
   end

   // Little-endian lane insert over the word just read back from the DM.
   always_comb begin
      merged = mem_rdata;
      case (size_q)
         SZ_BYTE: merged[8*lane_q +: 8] = data_q[7:0];
         SZ_HALF: begin
            if (lane_q[1]) merged[31:16] = data_q[15:0];
            else           merged[15:0]  = data_q[15:0];
         end
         default: merged = data_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         addr_q <= '0;
         lane_q <= '0;
         data_q <= '0;
         size_q <= '0;
         wbuf   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q <= req_addr[ADDR_W+1:2];
                  lane_q <= req_addr[1:0];
                  data_q <= req_wdata;
                  size_q <= req_size;
                  if (illegal) begin
                     state <= ERR;
                  end else if (req_size == SZ_WORD) begin
                     wbuf  <= req_wdata;
                     state <= WRITE;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ:  state <= MERGE;
            MERGE: begin
               wbuf  <= merged;
               state <= WRITE;
            end
            WRITE: state <= IDLE;
            ERR:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes are gated by reset so they are quiet even before the first reset edge.
   assign req_ready = reset && (state == IDLE);
   assign mem_rd_en = reset && (state == READ);
   assign mem_wr_en = reset && (state == WRITE);
   assign done      = reset && (state == WRITE);
   assign misalign  = reset && (state == ERR);
   assign mem_addr  = addr_q;
   assign mem_wdata = wbuf;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: behavioural word DM, write scoreboard, vector table plus reset/back-to-back sequences.
module tb_store_narrow_rmw;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        done;
   logic        misalign;
   logic [9:0]  mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
   logic        mem_wr_en;
   logic [31:0] mem_wdata;

   logic        pre_en;
   logic [9:0]  pre_addr;
   logic [31:0] pre_dat;
   logic [31:0] dm [0:1023];

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      bit          pre;
      logic [31:0] pre_dat;
      bit          err;
      logic [31:0] exp;
   } vec_t;

   wr_t  sb[$];
   vec_t vecs[15];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   rd_cnt = 0;
   int   wr_cnt = 0;

   store_narrow_rmw #(.ADDR_W(10)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .done(done), .misalign(misalign),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
      .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
   );

   always #5 clk = ~clk;

   // Synchronous data memory, one-cycle read latency.
   always @(posedge clk) begin
      if (pre_en)         dm[pre_addr] <= pre_dat;
      else if (mem_wr_en) dm[mem_addr] <= mem_wdata;
      if (mem_rd_en)      mem_rdata <= dm[mem_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Advance one cycle, sample just after the edge, retire any write against the scoreboard.
   task automatic step();
      wr_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (mem_rd_en) rd_cnt++;
      if (mem_wr_en) begin
         wr_cnt++;
         if (sb.size() == 0) begin
            chk("sb_unexpected_write", {31'd0, mem_wr_en}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_addr", {22'd0, mem_addr}, {22'd0, e.addr});
            chk("sb_data", mem_wdata, e.data);
            chk("sb_done", {31'd0, done}, 32'd1);
         end
      end
   endtask

   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      pre_addr = a;
      pre_dat  = d;
      pre_en   = 1'b1;
      step();
      pre_en   = 1'b0;
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, "_ready"}, {31'd0, req_ready}, 32'd0);
      chk({nm, "_done"},  {31'd0, done},      32'd0);
      chk({nm, "_mis"},   {31'd0, misalign},  32'd0);
      chk({nm, "_rd"},    {31'd0, mem_rd_en}, 32'd0);
      chk({nm, "_wr"},    {31'd0, mem_wr_en}, 32'd0);
      chk({nm, "_addr"},  {22'd0, mem_addr},  32'd0);
      chk({nm, "_wdata"}, mem_wdata,          32'd0);
   endtask

   initial begin
      int n, rd0, wr0, c1, c2, lat;
      logic [9:0] w;
      vec_t v;

      vecs[0]  = '{32'h0000_0008, 32'hDEAD_BEEF, 2'b10, 1'b1, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[1]  = '{32'h0000_000E, 32'h0000_00AB, 2'b00, 1'b1, 32'h1122_3344, 1'b0, 32'h11AB_3344};
      vecs[2]  = '{32'h0000_0002, 32'hFFFF_5566, 2'b01, 1'b1, 32'h1122_3344, 1'b0, 32'h5566_3344};
      vecs[3]  = '{32'h0000_0000, 32'hFFFF_5566, 2'b01, 1'b0, 32'h0,         1'b0, 32'h5566_5566};
      vecs[4]  = '{32'h0000_0005, 32'h1234_5678, 2'b01, 1'b1, 32'h5A5A_5A5A, 1'b1, 32'h5A5A_5A5A};
      vecs[5]  = '{32'h0000_0006, 32'h1234_5678, 2'b10, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5};
      vecs[6]  = '{32'h0000_0000, 32'h1234_5678, 2'b11, 1'b1, 32'h0F0F_0F0F, 1'b1, 32'h0F0F_0F0F};
      vecs[7]  = '{32'h0000_0020, 32'h1234_5678, 2'b00, 1'b1, 32'hAABB_CCDD, 1'b0, 32'hAABB_CC78};
      vecs[8]  = '{32'h0000_0021, 32'h0000_00FF, 2'b00, 1'b0, 32'h0,         1'b0, 32'hAABB_FF78};
      vecs[9]  = '{32'h0000_0023, 32'h0000_005A, 2'b00, 1'b0, 32'h0,         1'b0, 32'h5ABB_FF78};
      vecs[10] = '{32'hABCD_1FFC, 32'h0BAD_C0DE, 2'b10, 1'b1, 32'h0000_0000, 1'b0, 32'h0BAD_C0DE};
      vecs[11] = '{32'h0000_0003, 32'h1234_5678, 2'b11, 1'b1, 32'h7777_7777, 1'b1, 32'h7777_7777};
      vecs[12] = '{32'h0000_001E, 32'h1234_ABCD, 2'b01, 1'b1, 32'h0102_0304, 1'b0, 32'hABCD_0304};
      vecs[13] = '{32'h0000_0001, 32'h1234_5678, 2'b10, 1'b1, 32'h6666_6666, 1'b1, 32'h6666_6666};
      vecs[14] = '{32'h0000_0011, 32'hFFFF_FF3C, 2'b00, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_3C00};

      reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
      pre_en = 1'b0; pre_addr = '0; pre_dat = '0;

      repeat (3) step();
      chk_quiet("reset");
      reset = 1'b1;
      step();
      chk("post_reset_ready", {31'd0, req_ready}, 32'd1);

      foreach (vecs[i]) begin
         v = vecs[i];
         w = v.addr[11:2];
         if (v.pre) preload(w, v.pre_dat);
         chk($sformatf("v%0d_ready_pre", i), {31'd0, req_ready}, 32'd1);
         req_valid = 1'b1; req_addr = v.addr; req_wdata = v.wdata; req_size = v.size;
         if (!v.err) sb.push_back('{w, v.exp});
         rd0 = rd_cnt; wr0 = wr_cnt;
         step();
         req_valid = 1'b0;
         if (!v.err && v.size != 2'b10) begin
            chk($sformatf("v%0d_rd_en", i), {31'd0, mem_rd_en}, 32'd1);
            chk($sformatf("v%0d_rd_addr", i), {22'd0, mem_addr}, {22'd0, w});
         end
         n = 0;
         while (!(mem_wr_en || misalign) && n < 8) begin
            step();
            n++;
         end
         lat = (v.err || v.size == 2'b10) ? 0 : 2;
         chk($sformatf("v%0d_latency", i), n, lat);
         chk($sformatf("v%0d_misalign", i), {31'd0, misalign}, {31'd0, v.err});
         chk($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, !v.err});
         step();
         chk($sformatf("v%0d_ready_post", i), {31'd0, req_ready}, 32'd1);
         chk($sformatf("v%0d_rd_count", i), rd_cnt - rd0, (!v.err && v.size != 2'b10) ? 1 : 0);
         chk($sformatf("v%0d_wr_count", i), wr_cnt - wr0, v.err ? 0 : 1);
         chk($sformatf("v%0d_dm", i), dm[w], v.exp);
      end

      // Reset during MERGE abandons the byte store.
      preload(10'd5, 32'h0102_0304);
      rd0 = rd_cnt; wr0 = wr_cnt;
      req_valid = 1'b1; req_addr = 32'h14; req_wdata = 32'h99; req_size = 2'b00;
      step();
      req_valid = 1'b0;
      step();
      chk("rst_mid_rd_count", rd_cnt - rd0, 1);
      reset = 1'b0;
      step();
      chk_quiet("rst_mid_a");
      step();
      chk_quiet("rst_mid_b");
      reset = 1'b1;
      step();
      chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
      step();
      chk("rst_mid_wr_count", wr_cnt - wr0, 0);
      chk("rst_mid_dm", dm[5], 32'h0102_0304);

      // Back-to-back byte stores to one word with req_valid held high.
      preload(10'd4, 32'h0);
      sb.push_back('{10'd4, 32'h0000_00AA});
      sb.push_back('{10'd4, 32'h0000_BBAA});
      req_valid = 1'b1; req_addr = 32'h10; req_wdata = 32'hAA; req_size = 2'b00;
      step();
      req_addr = 32'h11; req_wdata = 32'hBB;
      n = 0;
      while (!mem_wr_en && n < 8) begin step(); n++; end
      chk("b2b_first_latency", n, 2);
      c1 = cyc;
      step();
      chk("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
      step();
      chk("b2b_second_rd", {31'd0, mem_rd_en}, 32'd1);
      req_valid = 1'b0;
      n = 0;
      while (!mem_wr_en && n < 8) begin step(); n++; end
      c2 = cyc;
      chk("b2b_spacing", c2 - c1, 4);
      step();
      chk("b2b_dm", dm[4], 32'h0000_BBAA);
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/store_narrow_rmw.md
Name: store_narrow_rmw

Overview:
- Store-side sub-word unit for the data memory path. Takes a 32-bit register value plus a byte/half/word store request and narrows it onto a word-only synchronous data memory.
- Byte and half stores use read-modify-write. Word stores are written directly.
- Sits between the datapath store request and the DM. Rejects misaligned or illegal requests without touching memory.

Parameters:
- ADDR_W, 10, word-address width of the DM (1024 words = 4 KB); mem_addr = req_addr[ADDR_W+1:2].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit can accept a request (IDLE only).
- req_addr  input  32  byte address of the store.
- req_wdata  input  32  register data. Byte uses [7:0], half uses [15:0].
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- done  output  1  one-cycle pulse, coincident with the memory write.
- misalign  output  1  one-cycle pulse when a request is rejected.
- mem_addr  output  ADDR_W  DM word address.
- mem_rd_en  output  1  DM read strobe.
- mem_rdata  input  32  DM read data, valid the cycle after mem_rd_en (latency 1).
- mem_wr_en  output  1  DM write strobe, word write at the clk edge.
- mem_wdata  output  32  DM write data.

Behaviour:
- State machine states: IDLE, READ, MERGE, WRITE, ERR. Outputs are Moore-decoded from state.
- While reset=0, every strobe and handshake output is forced to 0: req_ready, done, misalign, mem_rd_en, mem_wr_en.
- At any clk edge with reset=0:
  - state goes to IDLE;
  - latched addr/data/size and wbuf clear to 0;
  - mem_addr and mem_wdata read 0.
- First cycle after reset releases: state IDLE, req_ready=1.
- Accept: handshake at edge T when req_valid && req_ready. The unit latches addr, wdata and size at that edge.
- Illegal request: size=11, half with addr[0]=1, or word with addr[1:0]!=0.
  - Next state ERR; misalign=1 in cycle T+1.
  - No memory strobes.
  - Back to IDLE; req_ready=1 at T+2.
- Word store:
  - Next state WRITE: mem_wr_en=1, mem_wdata=latched data, done=1 in cycle T+1.
  - IDLE at T+2. mem_rd_en is never asserted.
- Byte/half store:
  - READ at T+1: mem_rd_en=1.
  - MERGE at T+2: mem_rdata is valid. wbuf <= merged word at the end of the cycle.
  - WRITE at T+3: mem_wr_en=1, mem_wdata=wbuf, done=1.
  - IDLE at T+4.
- Lane mapping is little-endian: lane k = bits [8k+7:8k], k = addr[1:0].
  - Byte store replaces lane addr[1:0] with wdata[7:0].
  - Half store replaces bits [15:0] (addr[1]=0) or [31:16] (addr[1]=1) with wdata[15:0].
  - All other bits come from mem_rdata.
- mem_addr holds the latched word address throughout READ, MERGE and WRITE.
- req_addr bits above ADDR_W+1 are ignored.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored and not queued.
- Back-to-back: a request can be accepted in the IDLE cycle immediately after WRITE or ERR. A following RMW to the same word reads the data just written.
- Reset mid-operation: the request is abandoned. No write is issued unless WRITE completed with reset=1 in that cycle.

Test Plan:
- Word store: reset, then req addr=0x00000008, data=0xDEADBEEF, size=10 -> at T+1: mem_wr_en=1, mem_addr=2, mem_wdata=0xDEADBEEF, done=1. mem_rd_en=0 throughout. req_ready=1 at T+2.
- Byte store: DM[3]=0x11223344; req addr=0x0000000E, data=0x000000AB, size=00 -> mem_rd_en at T+1 (mem_addr=3); at T+3: mem_wdata=0x11AB3344, done=1.
- Half store: DM[0]=0x11223344; req addr=0x00000002, data=0xFFFF5566, size=01 -> write 0x55663344 at T+3. Repeat at addr=0 -> 0x55665566.
- Misalign: sh addr=0x00000005, and sw addr=0x00000006 -> misalign=1 at T+1, no mem_rd_en/mem_wr_en, req_ready=1 at T+2. size=11 at addr 0 gives the same response.
- Reset mid-op: sb accepted, reset=0 during MERGE -> mem_wr_en never asserted. All outputs 0 while reset=0. req_ready=1 first cycle after release. DM unchanged.
- Back-to-back: req_valid held high, sb 0xAA to addr 0x10 then sb 0xBB to addr 0x11 over DM[4]=0 -> second accepted in the cycle after the first WRITE; final DM[4]=0x0000BBAA.
